// File: rtl/key_debouncer.sv
// Four independent push-button channels: 2-flop synchroniser, debounce FSM,
// and an optional hold-to-repeat timer. All pulse outputs are registered.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] KEY,
    output logic [3:0] PRESSED,
    output logic [3:0] PRESS_PULSE,
    output logic [3:0] RELEASE_PULSE,
    output logic [3:0] REPEAT_PULSE
);

    localparam int unsigned REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_W = $clog2(REP_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0] RPT_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_TOP   = REP_W'(REP_MAX);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PENDING,
        HELD,
        RELEASE_PENDING
    } state_e;

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    // Synchronisers reset to 1 so an idle (high) key looks released immediately.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_chan
        state_e           state_q;
        logic [CNT_W-1:0] deb_cnt_q;
        logic [REP_W-1:0] rep_cnt_q;
        logic             first_done_q;
        logic             pressed_q;
        logic             press_q;
        logic             release_q;
        logic             repeat_q;
        logic             key_up;
        logic             rep_fire;

        assign key_up   = sync2_q[k];
        assign rep_fire = first_done_q ? (rep_cnt_q == RPT_LAST) : (rep_cnt_q == HOLD_LAST);

        always_ff @(posedge CLOCK_50 or posedge RESET) begin
            if (RESET) begin
                state_q      <= RELEASED;
                deb_cnt_q    <= '0;
                rep_cnt_q    <= '0;
                first_done_q <= 1'b0;
                pressed_q    <= 1'b0;
                press_q      <= 1'b0;
                release_q    <= 1'b0;
                repeat_q     <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;

                // Repeat timer keeps running through a release glitch.
                if (state_q == HELD || state_q == RELEASE_PENDING) begin
                    repeat_q <= REPEAT_EN && rep_fire;
                    if (rep_fire) begin
                        rep_cnt_q    <= '0;
                        first_done_q <= 1'b1;
                    end else if (rep_cnt_q != REP_TOP) begin
                        rep_cnt_q <= rep_cnt_q + 1'b1;
                    end
                end

                case (state_q)
                    RELEASED: begin
                        if (!key_up) begin
                            state_q   <= PRESS_PENDING;
                            deb_cnt_q <= CNT_W'(1);
                        end
                    end
                    PRESS_PENDING: begin
                        if (key_up) begin
                            state_q   <= RELEASED;
                            deb_cnt_q <= '0;
                        end else if (deb_cnt_q == DEB_LAST) begin
                            state_q      <= HELD;
                            deb_cnt_q    <= '0;
                            pressed_q    <= 1'b1;
                            press_q      <= 1'b1;
                            rep_cnt_q    <= '0;
                            first_done_q <= 1'b0;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end
                    HELD: begin
                        if (key_up) begin
                            state_q   <= RELEASE_PENDING;
                            deb_cnt_q <= CNT_W'(1);
                        end
                    end
                    RELEASE_PENDING: begin
                        if (!key_up) begin
                            state_q   <= HELD;
                            deb_cnt_q <= '0;
                        end else if (deb_cnt_q == DEB_LAST) begin
                            // No repeat on the cycle the key is finally let go.
                            state_q   <= RELEASED;
                            deb_cnt_q <= '0;
                            pressed_q <= 1'b0;
                            release_q <= 1'b1;
                            repeat_q  <= 1'b0;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= RELEASED;
                endcase
            end
        end

        assign PRESSED[k]       = pressed_q;
        assign PRESS_PULSE[k]   = press_q;
        assign RELEASE_PULSE[k] = release_q;
        assign REPEAT_PULSE[k]  = repeat_q;
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: stimulus queues expected output events,
// a negedge monitor pops and compares whenever the outputs show activity.
module tb_key_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic [3:0] pressed, press_p, release_p, repeat_p;

    key_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (3),
        .REPEAT_EN      (1'b1)
    ) dut (
        .CLOCK_50     (clk),
        .RESET        (rst),
        .KEY          (key),
        .PRESSED      (pressed),
        .PRESS_PULSE  (press_p),
        .RELEASE_PULSE(release_p),
        .REPEAT_PULSE (repeat_p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] pressed;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rpt;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    logic [3:0] prev_pressed = 4'b0000;

    task automatic push(input int t, input logic [3:0] p, input logic [3:0] pp,
                        input logic [3:0] rp, input logic [3:0] rr);
        ev_t e;
        e.cyc = t; e.pressed = p; e.press = pp; e.rel = rp; e.rpt = rr;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: any pulse or a change of PRESSED is an output event.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if ((press_p | release_p | repeat_p) != 4'b0000 || pressed != prev_pressed) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: cyc=%0d pressed=%b press=%b release=%b repeat=%b",
                             cyc, pressed, press_p, release_p, repeat_p);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.pressed !== pressed || e.press !== press_p ||
                        e.rel !== release_p || e.rpt !== repeat_p) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d pressed=%b press=%b release=%b repeat=%b, expected cyc=%0d pressed=%b press=%b release=%b repeat=%b",
                                 cyc, pressed, press_p, release_p, repeat_p,
                                 e.cyc, e.pressed, e.press, e.rel, e.rpt);
                    end
                end
            end
            prev_pressed = pressed;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a;
        int k;
        int r;

        rst = 1'b1;
        key = 4'hF;
        tick(3);
        check("reset_pressed", pressed, 4'b0000);
        check("reset_press", press_p, 4'b0000);
        check("reset_release", release_p, 4'b0000);
        check("reset_repeat", repeat_p, 4'b0000);
        rst = 1'b0;
        mon_en = 1'b1;
        tick(3);

        // Clean press on key 0 with a 2-cycle release glitch while held.
        a = cyc + 7;
        key[0] = 1'b0;
        push(a,      4'b0001, 4'b0001, 4'b0000, 4'b0000);
        push(a + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        push(a + 13, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        push(a + 16, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        push(a + 19, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        push(a + 21, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        goto(a + 2);  key[0] = 1'b1;
        goto(a + 4);  key[0] = 1'b0;
        goto(a + 14); key[0] = 1'b1;
        goto(a + 30);

        // Bounce on key 1: low 3, high 1, low 3, high. Must produce nothing.
        key[1] = 1'b0; tick(3);
        key[1] = 1'b1; tick(1);
        key[1] = 1'b0; tick(3);
        key[1] = 1'b1; tick(15);

        // Long hold on key 2: repeats at hold cycles 10,13,...,34 then release.
        a = cyc + 7;
        key[2] = 1'b0;
        push(a, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        for (int t = 10; t <= 34; t += 3)
            push(a + t, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        push(a + 36, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        goto(a + 29); key[2] = 1'b1;
        goto(a + 45);

        // All four keys together.
        a = cyc + 7;
        key = 4'b0000;
        push(a,      4'b1111, 4'b1111, 4'b0000, 4'b0000);
        push(a + 10, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        push(a + 13, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        push(a + 16, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        push(a + 18, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        goto(a + 11); key = 4'hF;
        goto(a + 25);

        // Reset with key 2 held and key 3 mid-debounce; both re-debounce afterwards.
        a = cyc + 7;
        key[2] = 1'b0;
        push(a, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        goto(a + 3); key[3] = 1'b0;
        goto(a + 7);
        k = cyc;
        push(k + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        #2 rst = 1'b1;
        #1;
        check("rst_async_pressed", pressed, 4'b0000);
        check("rst_async_press", press_p, 4'b0000);
        check("rst_async_release", release_p, 4'b0000);
        check("rst_async_repeat", repeat_p, 4'b0000);
        goto(k + 2);
        rst = 1'b0;
        r = cyc;
        push(r + 7,  4'b1100, 4'b1100, 4'b0000, 4'b0000);
        push(r + 16, 4'b0000, 4'b0000, 4'b1100, 4'b0000);
        goto(r + 9); key = 4'hF;
        goto(r + 30);

        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: expected cyc=%0d pressed=%b press=%b release=%b repeat=%b, not observed",
                     e.cyc, e.pressed, e.press, e.rel, e.rpt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
